// File: rtl/esp_line_framer_pkg.sv
// Shared types and constants for the ESP32 line framer: FSM states, ASCII
// terminators, the response strings and a per-character match helper.
package esp_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DRAIN   = 2'd1,
      DISCARD = 2'd2
   } state_e;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Strings are right-aligned: the final character sits in bits [7:0].
   localparam logic [39:0] RSP_OK      = {24'h000000, "OK"};
   localparam logic [39:0] RSP_ERR     = "ERROR";
   localparam int          RSP_OK_LEN  = 2;
   localparam int          RSP_ERR_LEN = 5;

   function automatic logic str_match(input logic [39:0] s, input int len,
                                      input int idx, input logic [7:0] b);
      logic [39:0] t;
      if (idx >= len) return 1'b0;
      t = s >> (8 * (len - 1 - idx));
      return (t[7:0] == b);
   endfunction

endpackage

// File: rtl/esp_line_framer_if.sv
// Byte-stream bundle between the UART receiver, the line framer and the
// command/response consumer, plus the framer's status pulses.
interface esp_line_framer_if #(parameter int CNT_W = 7);

   logic [7:0]       s_data;
   logic             s_valid;
   logic             s_ready;
   logic [7:0]       m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic [CNT_W-1:0] m_len;
   logic             line_done;
   logic             ovf;
   logic             rsp_ok;
   logic             rsp_err;

   modport slave (
      input  s_data, s_valid, m_ready,
      output s_ready, m_data, m_valid, m_last, m_len, line_done, ovf, rsp_ok, rsp_err
   );

   modport master (
      output s_data, s_valid, m_ready,
      input  s_ready, m_data, m_valid, m_last, m_len, line_done, ovf, rsp_ok, rsp_err
   );

endinterface

// File: rtl/esp_line_framer_buf.sv
// Line payload storage: one synchronous write port, one combinational read port.
module esp_line_buf
   import esp_pkg::*;
#(
   parameter int MAX_LEN = 64,
   parameter int AW      = $clog2(MAX_LEN)
)
(
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [MAX_LEN];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/esp_line_framer.sv
// Assembles CR/LF-terminated ASCII lines from the ESP32 UART stream and replays
// them as framed bytes. Define ESP_FRAMER_MATCH_EN to enable "OK"/"ERROR" detection.
module esp_line_framer
   import esp_pkg::*;
#(
   parameter int MAX_LEN = 64
)
(
   input  logic               clk_i,
   input  logic               rst_ni,
   esp_line_framer_if.slave   bus
);

   localparam int               CNT_W   = $clog2(MAX_LEN + 1);
   localparam int               AW      = $clog2(MAX_LEN);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] rd_idx_q;
   logic [CNT_W-1:0] len_q;
   logic             line_done_q;
   logic             ovf_q;

   logic [7:0] rd_data;
   logic       s_ready, m_valid, m_last;
   logic       s_fire, m_fire, is_cr, is_lf, wr_en, lf_close;

   assign s_ready  = (state_q != DRAIN);
   assign m_valid  = (state_q == DRAIN);
   assign m_last   = m_valid && (rd_idx_q == len_q - ONE);
   assign s_fire   = bus.s_valid && s_ready;
   assign m_fire   = m_valid && bus.m_ready;
   assign is_cr    = (bus.s_data == ASCII_CR);
   assign is_lf    = (bus.s_data == ASCII_LF);
   assign wr_en    = (state_q == COLLECT) && s_fire && !is_cr && !is_lf && (count_q != MAX_CNT);
   assign lf_close = (state_q == COLLECT) && s_fire && is_lf && (count_q != '0);

   esp_line_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
      .clk_i   (clk_i),
      .we_i    (wr_en),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (bus.s_data),
      .raddr_i (rd_idx_q[AW-1:0]),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= COLLECT;
         count_q     <= '0;
         rd_idx_q    <= '0;
         len_q       <= '0;
         line_done_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         line_done_q <= 1'b0;
         ovf_q       <= 1'b0;
         case (state_q)
            COLLECT: begin
               if (lf_close) begin
                  state_q  <= DRAIN;
                  rd_idx_q <= '0;
                  len_q    <= count_q;
               end else if (wr_en) begin
                  count_q <= count_q + ONE;
               end else if (s_fire && !is_cr && !is_lf) begin
                  // One byte past a full buffer: abandon the line until its LF.
                  ovf_q   <= 1'b1;
                  count_q <= '0;
                  state_q <= DISCARD;
               end
            end
            DISCARD: begin
               if (s_fire && is_lf) state_q <= COLLECT;
            end
            DRAIN: begin
               if (m_fire) begin
                  if (m_last) begin
                     line_done_q <= 1'b1;
                     count_q     <= '0;
                     rd_idx_q    <= '0;
                     state_q     <= COLLECT;
                  end else begin
                     rd_idx_q <= rd_idx_q + ONE;
                  end
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.m_valid   = m_valid;
   assign bus.m_data    = m_valid ? rd_data : 8'h00;
   assign bus.m_last    = m_last;
   assign bus.m_len     = len_q;
   assign bus.line_done = line_done_q;
   assign bus.ovf       = ovf_q;

`ifdef ESP_FRAMER_MATCH_EN
   // Prefix flags track, byte by byte, whether the line so far still spells each response.
   logic ok_pref_q, err_pref_q, ok_pref_d, err_pref_d;
   logic rsp_ok_q, rsp_err_q;

   always_comb begin
      ok_pref_d  = str_match(RSP_OK, RSP_OK_LEN, int'(count_q), bus.s_data)
                   && ((count_q == '0) || ok_pref_q);
      err_pref_d = str_match(RSP_ERR, RSP_ERR_LEN, int'(count_q), bus.s_data)
                   && ((count_q == '0) || err_pref_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ok_pref_q  <= 1'b0;
         err_pref_q <= 1'b0;
         rsp_ok_q   <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         rsp_ok_q  <= 1'b0;
         rsp_err_q <= 1'b0;
         if (wr_en) begin
            ok_pref_q  <= ok_pref_d;
            err_pref_q <= err_pref_d;
         end
         if (lf_close) begin
            rsp_ok_q  <= ok_pref_q  && (count_q == CNT_W'(RSP_OK_LEN));
            rsp_err_q <= err_pref_q && (count_q == CNT_W'(RSP_ERR_LEN));
         end
      end
   end

   assign bus.rsp_ok  = rsp_ok_q;
   assign bus.rsp_err = rsp_err_q;
`else
   assign bus.rsp_ok  = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_esp_line_framer.sv
// Directed bench for esp_line_framer: line assembly, empty/overlong lines,
// backpressure, full-length lines and reset during drain.
module tb_esp_line_framer;

`ifdef ESP_FRAMER_MATCH_EN
   localparam int MATCH = 1;
`else
   localparam int MATCH = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   esp_line_framer_if #(.CNT_W(7)) bus();

   esp_line_framer #(.MAX_LEN(64)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   int readyMode = 0;
   int ldCnt, ovfCnt, okCnt, errCnt, rspNoValid;
   logic [7:0] rxData[$];
   bit         rxLast[$];
   int         rxLen[$];
   bit         prevValid, prevReady;
   logic [7:0] prevData;
   logic       prevLast;

   // Output monitor: drives m_ready, records handshaken bytes and pulses, and
   // checks that a stalled beat holds steady and that the input side is closed.
   initial begin
      bus.m_ready = 1'b1;
      prevValid = 1'b0;
      forever begin
         @(negedge clk);
         bus.m_ready = (readyMode == 1) ? ~bus.m_ready : 1'b1;
         if (rst_n) begin
            if (prevValid && !prevReady) begin
               checks++;
               if (bus.m_valid !== 1'b1 || bus.m_data !== prevData || bus.m_last !== prevLast) begin
                  errors++;
                  $display("[TB] FAIL stall_hold valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                           bus.m_valid, bus.m_data, bus.m_last, prevData, prevLast);
               end
            end
            if (bus.m_valid === 1'b1) begin
               checks++;
               if (bus.s_ready !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL s_ready_in_drain got=%b required=0", bus.s_ready);
               end
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
               rxData.push_back(bus.m_data);
               rxLast.push_back(bus.m_last);
               rxLen.push_back(int'(bus.m_len));
            end
            if (bus.line_done === 1'b1) ldCnt++;
            if (bus.ovf === 1'b1) ovfCnt++;
            if (bus.rsp_ok === 1'b1) okCnt++;
            if (bus.rsp_err === 1'b1) errCnt++;
            if ((bus.rsp_ok === 1'b1 || bus.rsp_err === 1'b1) && bus.m_valid !== 1'b1) rspNoValid++;
            prevValid = (bus.m_valid === 1'b1);
            prevReady = bus.m_ready;
            prevData  = bus.m_data;
            prevLast  = bus.m_last;
         end else begin
            prevValid = 1'b0;
         end
      end
   end

   task automatic clearMon();
      ldCnt = 0; ovfCnt = 0; okCnt = 0; errCnt = 0; rspNoValid = 0;
      rxData.delete(); rxLast.delete(); rxLen.delete();
   endtask

   // Sends each character, waiting out s_ready stalls; returns on the falling
   // edge after the final byte was accepted.
   task automatic applyStimulus(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         bus.s_data  = s[i];
         bus.s_valid = 1'b1;
         for (int g = 0; g < 200 && bus.s_ready !== 1'b1; g++) begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
   endtask

   task automatic waitLines(input int n);
      for (int g = 0; g < 400 && ldCnt < n; g++) begin
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.s_ready, bus.m_valid, bus.m_last, bus.line_done, bus.ovf, bus.rsp_ok, bus.rsp_err} !== 7'b1000000) begin
         errors++;
         $display("[TB] FAIL reset_flags got=%b required=1000000",
                  {bus.s_ready, bus.m_valid, bus.m_last, bus.line_done, bus.ovf, bus.rsp_ok, bus.rsp_err});
      end
      checks++;
      if (bus.m_data !== 8'h00 || bus.m_len !== 7'd0) begin
         errors++;
         $display("[TB] FAIL reset_data m_data=%h m_len=%0d required 00 and 0", bus.m_data, bus.m_len);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL post_reset m_valid=%b s_ready=%b required 0 and 1", bus.m_valid, bus.s_ready);
      end
   endtask

   task automatic test_ok();
      string e = "OK";
      clearMon();
      readyMode = 0;
      applyStimulus("OK\r\n");
      checks++;
      if (bus.m_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ok_latency m_valid=%b required=1", bus.m_valid);
      end
      waitLines(1);
      checks++;
      if (rxData.size() != e.len()) begin
         errors++;
         $display("[TB] FAIL ok_count got=%0d required=%0d", rxData.size(), e.len());
      end
      for (int i = 0; i < e.len() && i < rxData.size(); i++) begin
         checks++;
         if (rxData[i] !== e[i] || rxLast[i] !== (i == e.len() - 1) || rxLen[i] != e.len()) begin
            errors++;
            $display("[TB] FAIL ok_byte%0d got=%h/%b/%0d required=%h/%b/%0d", i, rxData[i], rxLast[i],
                     rxLen[i], e[i], (i == e.len() - 1), e.len());
         end
      end
      checks++;
      if (ldCnt != 1 || ovfCnt != 0 || okCnt != MATCH || errCnt != 0) begin
         errors++;
         $display("[TB] FAIL ok_pulses done=%0d ovf=%0d ok=%0d err=%0d required 1 0 %0d 0",
                  ldCnt, ovfCnt, okCnt, errCnt, MATCH);
      end
   endtask

   task automatic test_empty_lines();
      string e = "AB";
      clearMon();
      applyStimulus("\r\n\r\n");
      repeat (5) @(negedge clk);
      checks++;
      if (rxData.size() != 0 || ldCnt != 0) begin
         errors++;
         $display("[TB] FAIL empty_dropped bytes=%0d done=%0d required 0 0", rxData.size(), ldCnt);
      end
      applyStimulus("AB\n");
      waitLines(1);
      checks++;
      if (rxData.size() != e.len() || ldCnt != 1) begin
         errors++;
         $display("[TB] FAIL ab_count bytes=%0d done=%0d required %0d 1", rxData.size(), ldCnt, e.len());
      end
      for (int i = 0; i < e.len() && i < rxData.size(); i++) begin
         checks++;
         if (rxData[i] !== e[i] || rxLast[i] !== (i == e.len() - 1) || rxLen[i] != e.len()) begin
            errors++;
            $display("[TB] FAIL ab_byte%0d got=%h/%b/%0d required=%h/%b/%0d", i, rxData[i], rxLast[i],
                     rxLen[i], e[i], (i == e.len() - 1), e.len());
         end
      end
   endtask

   task automatic test_overflow();
      string s = "";
      for (int i = 0; i < 65; i++) s = {s, "A"};
      s = {s, "\n"};
      clearMon();
      applyStimulus(s);
      repeat (5) @(negedge clk);
      checks++;
      if (ovfCnt != 1 || rxData.size() != 0 || ldCnt != 0) begin
         errors++;
         $display("[TB] FAIL ovf_long ovf=%0d bytes=%0d done=%0d required 1 0 0", ovfCnt, rxData.size(), ldCnt);
      end
      applyStimulus("X\n");
      waitLines(1);
      checks++;
      if (rxData.size() != 1 || ovfCnt != 1 || ldCnt != 1) begin
         errors++;
         $display("[TB] FAIL ovf_recover bytes=%0d ovf=%0d done=%0d required 1 1 1", rxData.size(), ovfCnt, ldCnt);
      end else if (rxData[0] !== 8'h58 || rxLast[0] !== 1'b1 || rxLen[0] != 1) begin
         errors++;
         $display("[TB] FAIL ovf_x_byte got=%h/%b/%0d required=58/1/1", rxData[0], rxLast[0], rxLen[0]);
      end
   endtask

   task automatic test_error_stall();
      string e = "ERROR";
      clearMon();
      readyMode = 1;
      applyStimulus("ERROR\r\n");
      waitLines(1);
      readyMode = 0;
      checks++;
      if (rxData.size() != e.len()) begin
         errors++;
         $display("[TB] FAIL err_count got=%0d required=%0d", rxData.size(), e.len());
      end
      for (int i = 0; i < e.len() && i < rxData.size(); i++) begin
         checks++;
         if (rxData[i] !== e[i] || rxLast[i] !== (i == e.len() - 1) || rxLen[i] != e.len()) begin
            errors++;
            $display("[TB] FAIL err_byte%0d got=%h/%b/%0d required=%h/%b/%0d", i, rxData[i], rxLast[i],
                     rxLen[i], e[i], (i == e.len() - 1), e.len());
         end
      end
      checks++;
      if (ldCnt != 1 || errCnt != MATCH || okCnt != 0 || rspNoValid != 0) begin
         errors++;
         $display("[TB] FAIL err_pulses done=%0d err=%0d ok=%0d early=%0d required 1 %0d 0 0",
                  ldCnt, errCnt, okCnt, rspNoValid, MATCH);
      end
   endtask

   task automatic test_full_line();
      string s = "";
      for (int i = 0; i < 64; i++) s = $sformatf("%s%c", s, 8'h21 + i);
      clearMon();
      applyStimulus({s, "\n"});
      waitLines(1);
      checks++;
      if (rxData.size() != 64 || ovfCnt != 0 || ldCnt != 1) begin
         errors++;
         $display("[TB] FAIL full_count bytes=%0d ovf=%0d done=%0d required 64 0 1", rxData.size(), ovfCnt, ldCnt);
      end
      for (int i = 0; i < 64 && i < rxData.size(); i++) begin
         checks++;
         if (rxData[i] !== 8'(8'h21 + i) || rxLast[i] !== (i == 63) || rxLen[i] != 64) begin
            errors++;
            $display("[TB] FAIL full_byte%0d got=%h/%b/%0d required=%h/%b/64", i, rxData[i], rxLast[i],
                     rxLen[i], 8'(8'h21 + i), (i == 63));
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      string e = "HI";
      clearMon();
      readyMode = 0;
      applyStimulus("HELLO\n");
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.s_ready, bus.m_valid, bus.m_last, bus.line_done, bus.ovf} !== 5'b10000 || bus.m_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL abort_async flags=%b data=%h required 10000 and 00",
                  {bus.s_ready, bus.m_valid, bus.m_last, bus.line_done, bus.ovf}, bus.m_data);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || ldCnt != 0 || rxData.size() != 2) begin
         errors++;
         $display("[TB] FAIL abort_release m_valid=%b s_ready=%b done=%0d bytes=%0d required 0 1 0 2",
                  bus.m_valid, bus.s_ready, ldCnt, rxData.size());
      end
      clearMon();
      applyStimulus("HI\n");
      waitLines(1);
      checks++;
      if (rxData.size() != e.len() || ldCnt != 1 || ovfCnt != 0) begin
         errors++;
         $display("[TB] FAIL hi_count bytes=%0d done=%0d ovf=%0d required 2 1 0", rxData.size(), ldCnt, ovfCnt);
      end
      for (int i = 0; i < e.len() && i < rxData.size(); i++) begin
         checks++;
         if (rxData[i] !== e[i] || rxLast[i] !== (i == e.len() - 1) || rxLen[i] != e.len()) begin
            errors++;
            $display("[TB] FAIL hi_byte%0d got=%h/%b/%0d required=%h/%b/%0d", i, rxData[i], rxLast[i],
                     rxLen[i], e[i], (i == e.len() - 1), e.len());
         end
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      clearMon();
      test_reset();
      test_ok();
      test_empty_lines();
      test_overflow();
      test_error_stall();
      test_full_line();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
